// File: rtl/ysyx_24120013_pkg.sv
// Shared register-file definitions: index/data widths, register count and the
// helper that decides whether an index names a writable register.
package ysyx_24120013_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;
    localparam int NUM_REGS       = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

    // x0 and indices past the implemented range behave as hard-wired zero
    function automatic logic idx_valid(input reg_idx_t idx, input int unsigned nregs);
        return (idx != REG_ZERO) && (32'(idx) < nregs);
    endfunction

endpackage

// File: rtl/ysyx_24120013_scoreboard.sv
// Busy-bit scoreboard: one pending-producer flag per implemented register,
// looked up for both source operands and masked when write-back bypasses them.
module ysyx_24120013_scoreboard
    import ysyx_24120013_pkg::*;
#(
    parameter int NUM_REGS = ysyx_24120013_pkg::NUM_REGS
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_issue_valid,
    input  reg_idx_t i_issue_rd,
    input  logic     i_wr_valid,
    input  reg_idx_t i_waddr,
    input  reg_idx_t i_raddr1,
    input  reg_idx_t i_raddr2,
    output logic     o_busy1,
    output logic     o_busy2
);

    logic [2**REG_ADDR_WIDTH-1:0] w_busy;

    genvar gi;
    generate
        for (gi = 0; gi < 2**REG_ADDR_WIDTH; gi++) begin : g_busy
            if (gi == 0 || gi >= NUM_REGS) begin : g_none
                assign w_busy[gi] = 1'b0;
            end else begin : g_bit
                logic r_busy;
                logic w_set;
                logic w_clr;

                assign w_set = i_issue_valid && (i_issue_rd == reg_idx_t'(gi));
                assign w_clr = i_wr_valid && (i_waddr == reg_idx_t'(gi));

                // A same-cycle set beats the clear: the newer producer is still in flight
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_busy <= 1'b0;
                    end else if (w_set) begin
                        r_busy <= 1'b1;
                    end else if (w_clr) begin
                        r_busy <= 1'b0;
                    end
                end

                assign w_busy[gi] = r_busy;
            end
        end
    endgenerate

    assign o_busy1 = w_busy[i_raddr1] & ~(i_wr_valid && (i_waddr == i_raddr1));
    assign o_busy2 = w_busy[i_raddr2] & ~(i_wr_valid && (i_waddr == i_raddr2));

endmodule

// File: rtl/ysyx_24120013_regfile.sv
// General-purpose register file: EXU write port, two bypassed IDU read ports,
// an unbypassed difftest port and the busy scoreboard for operand stalls.
module ysyx_24120013_regfile
    import ysyx_24120013_pkg::*;
#(
    parameter int DATA_WIDTH = ysyx_24120013_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = ysyx_24120013_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  reg_idx_t              waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  reg_idx_t              raddr1,
    input  reg_idx_t              raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  issue_valid,
    input  reg_idx_t              issue_rd,
    output logic                  busy1,
    output logic                  busy2,
    input  reg_idx_t              dbg_raddr,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    logic                  w_wr_valid;
    logic                  w_issue_valid;
    logic [DATA_WIDTH-1:0] w_regs [2**REG_ADDR_WIDTH];

    // Gating with rst keeps the bypass from leaking wdata while reset is held
    assign w_wr_valid    = rst && wen && idx_valid(waddr, NUM_REGS);
    assign w_issue_valid = issue_valid && idx_valid(issue_rd, NUM_REGS);

    genvar gi;
    generate
        for (gi = 0; gi < 2**REG_ADDR_WIDTH; gi++) begin : g_reg
            if (gi == 0 || gi >= NUM_REGS) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_store
                logic [DATA_WIDTH-1:0] r_q;

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_q <= '0;
                    end else if (w_wr_valid && (waddr == reg_idx_t'(gi))) begin
                        r_q <= wdata;
                    end
                end

                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    assign rdata1    = (w_wr_valid && (waddr == raddr1)) ? wdata : w_regs[raddr1];
    assign rdata2    = (w_wr_valid && (waddr == raddr2)) ? wdata : w_regs[raddr2];
    assign dbg_rdata = w_regs[dbg_raddr];

    ysyx_24120013_scoreboard #(
        .NUM_REGS(NUM_REGS)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_issue_valid (w_issue_valid),
        .i_issue_rd    (issue_rd),
        .i_wr_valid    (w_wr_valid),
        .i_waddr       (waddr),
        .i_raddr1      (raddr1),
        .i_raddr2      (raddr2),
        .o_busy1       (busy1),
        .o_busy2       (busy2)
    );

endmodule
